// File: rtl/be_row_collect_pkg.sv
// be_row_collect_pkg: constants and helpers shared by the back-end row path.
// Holds the transform size encodings, the row/lane geometry and the row and lane
// helpers used by the delay, DCT and row-collect stages.
package be_row_collect_pkg;

  localparam int unsigned NUM_LANES = 32;  // coefficient lanes per row
  localparam int unsigned LANE_W    = 28;  // bits per lane
  localparam int unsigned IDX_W     = 5;   // row index width (up to 32 rows)

  typedef enum logic [1:0] {
    TS_4  = 2'd0,
    TS_8  = 2'd1,
    TS_16 = 2'd2,
    TS_32 = 2'd3
  } ts_e;

  // Rows in a block; equals the number of active lanes for the same size.
  function automatic logic [5:0] rows_per_blk(input logic [1:0] size);
    return 6'd4 << size;
  endfunction

  // One bit per lane, set for lanes inside the active transform width.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size);
    logic [NUM_LANES-1:0] m;
    for (int k = 0; k < NUM_LANES; k++) begin
      m[k] = (k < int'(rows_per_blk(size)));
    end
    return m;
  endfunction

endpackage

// File: rtl/be_row_collect_if.sv
// be_row_collect_if: row stream into the collector and framed rows out of it.
//   i_dt_vld / i_transize / i_data : aligned row from the delay stage (no ready)
//   i_rdy                          : downstream ready
//   i_clr_err                      : clears sticky error flags
//   o_vld / o_data / o_transize / o_row_idx / o_first / o_last : FIFO head row
//   o_ovf / o_size_err             : sticky error flags
// master drives the inputs (producer + consumer side), slave is the collector.
interface be_row_collect_if
  import be_row_collect_pkg::*;
#(
  parameter int unsigned LANES = NUM_LANES,
  parameter int unsigned DW    = LANE_W
);

  logic                  i_dt_vld;
  logic [1:0]            i_transize;
  logic [LANES*DW-1:0]   i_data;
  logic                  i_rdy;
  logic                  i_clr_err;
  logic                  o_vld;
  logic [LANES*DW-1:0]   o_data;
  logic [1:0]            o_transize;
  logic [IDX_W-1:0]      o_row_idx;
  logic                  o_first;
  logic                  o_last;
  logic                  o_ovf;
  logic                  o_size_err;

  modport master (
    output i_dt_vld, i_transize, i_data, i_rdy, i_clr_err,
    input  o_vld, o_data, o_transize, o_row_idx, o_first, o_last, o_ovf, o_size_err
  );

  modport slave (
    input  i_dt_vld, i_transize, i_data, i_rdy, i_clr_err,
    output o_vld, o_data, o_transize, o_row_idx, o_first, o_last, o_ovf, o_size_err
  );

endinterface

// File: rtl/be_row_fifo.sv
// be_row_fifo: generic first-word-fall-through synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request; accepted when not full, or when full and popping
//   pop        : read request; ignored when empty
//   rdata      : head entry (valid while !empty)
//   full/empty : occupancy status
module be_row_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/be_row_collect.sv
// be_row_collect: frames the aligned row stream into transform blocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : be_row_collect_if slave (row in, framed rows out, sticky flags)
// Each incoming row is tagged with its index and first/last flags, lanes beyond
// the block width are zeroed, and the row is queued for the downstream stage.
// The producer cannot be stalled, so a row arriving at a full FIFO is dropped.
module be_row_collect
  import be_row_collect_pkg::*;
#(
  parameter int unsigned LANES = NUM_LANES,
  parameter int unsigned DW    = LANE_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  be_row_collect_if.slave  bus
);

  localparam int unsigned DATA_W  = LANES * DW;
  localparam int unsigned ENTRY_W = DATA_W + 2 + IDX_W + 2;

  logic [IDX_W-1:0]   row_cnt_q;
  ts_e                blk_size_q;
  logic               ovf_q;
  logic               size_err_q;

  ts_e                eff_size;
  logic [5:0]         rpb;
  logic               last_row;
  logic               first_row;
  logic               size_mis;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  masked;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // Row 0 of a block takes its size from the stream; later rows reuse the latch.
  assign first_row = (row_cnt_q == '0);
  assign eff_size  = first_row ? ts_e'(bus.i_transize) : blk_size_q;
  assign rpb       = rows_per_blk(eff_size);
  assign last_row  = ({1'b0, row_cnt_q} == (rpb - 6'd1));
  assign size_mis  = bus.i_dt_vld && !first_row && (bus.i_transize != blk_size_q);

  assign pop  = bus.o_vld && bus.i_rdy;
  assign drop = bus.i_dt_vld && fifo_full && !pop;

  always_comb begin
    masked = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (k < int'(rpb)) begin
        masked[k*DW +: DW] = bus.i_data[k*DW +: DW];
      end
    end
  end

  assign wdata = {last_row, first_row, row_cnt_q, eff_size, masked};

  be_row_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.i_dt_vld),
    .wdata (wdata),
    .pop   (bus.i_rdy),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Framing advances on every valid row, dropped or not, so block alignment
  // with the producer survives an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q  <= '0;
      blk_size_q <= TS_4;
    end else if (bus.i_dt_vld) begin
      row_cnt_q <= last_row ? '0 : row_cnt_q + IDX_W'(1);
      if (first_row) begin
        blk_size_q <= ts_e'(bus.i_transize);
      end
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.i_clr_err) begin
        ovf_q <= 1'b0;
      end
      if (size_mis) begin
        size_err_q <= 1'b1;
      end else if (bus.i_clr_err) begin
        size_err_q <= 1'b0;
      end
    end
  end

  assign bus.o_vld      = !fifo_empty;
  assign bus.o_data     = rdata[DATA_W-1:0];
  assign bus.o_transize = rdata[DATA_W +: 2];
  assign bus.o_row_idx  = rdata[DATA_W+2 +: IDX_W];
  assign bus.o_first    = rdata[DATA_W+2+IDX_W];
  assign bus.o_last     = rdata[DATA_W+3+IDX_W];
  assign bus.o_ovf      = ovf_q;
  assign bus.o_size_err = size_err_q;

endmodule

// File: tb/tb_be_row_collect.sv
// tb_be_row_collect: scoreboard bench for be_row_collect.
// Stimulus pushes the expected framed row for every row that should be stored;
// a monitor pops and compares whenever the DUT hands a row downstream.
module tb_be_row_collect;
  import be_row_collect_pkg::*;

  localparam int unsigned L = NUM_LANES;
  localparam int unsigned W = LANE_W;

  typedef struct {
    logic [L*W-1:0] data;
    logic [1:0]     sz;
    logic [4:0]     idx;
    logic           first;
    logic           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_nobypass = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  be_row_collect_if bus ();

  be_row_collect #(
    .LANES (L),
    .DW    (W),
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [L*W-1:0] make_row(input int seed);
    logic [L*W-1:0] r;
    for (int k = 0; k < int'(L); k++) begin
      r[k*W +: W] = {8'(seed), 8'(k), 12'hA5C};
    end
    return r;
  endfunction

  function automatic logic [L*W-1:0] mask_row(input logic [L*W-1:0] row, input logic [1:0] sz);
    logic [L*W-1:0] r;
    r = row;
    for (int k = 0; k < int'(L); k++) begin
      if (k >= (4 << sz)) r[k*W +: W] = '0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; presents one row for one cycle.
  task automatic send_row(input logic [1:0] sz, input int seed, input logic [1:0] exp_sz,
                          input int idx, input bit store);
    exp_t e;
    bus.i_dt_vld   = 1'b1;
    bus.i_transize = sz;
    bus.i_data     = make_row(seed);
    if (store) begin
      e.data  = mask_row(make_row(seed), exp_sz);
      e.sz    = exp_sz;
      e.idx   = 5'(idx);
      e.first = (idx == 0);
      e.last  = (idx == (4 << exp_sz) - 1);
      sb.push_back(e);
    end
    if (chk_nobypass) begin
      #1;
      check("no_bypass_vld", 32'(bus.o_vld), 32'(0));
    end
    @(posedge clk);
    #1;
    bus.i_dt_vld = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_done", 32'(sb.size()), 32'(0));
  endtask

  task automatic clr_pulse();
    bus.i_clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.i_clr_err = 1'b0;
  endtask

  // Monitor: a row leaves the DUT at the next rising edge when o_vld & i_rdy.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.o_vld === 1'b1 && bus.i_rdy === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_row got idx=%0d exp=none at %0t", bus.o_row_idx, $time);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bus.o_data !== e.data) begin
            failures++;
            for (int k = 0; k < int'(L); k++) begin
              if (bus.o_data[k*W +: W] !== e.data[k*W +: W]) begin
                $display("FAIL row_data idx=%0d lane=%0d got=%h exp=%h", e.idx, k,
                         bus.o_data[k*W +: W], e.data[k*W +: W]);
                break;
              end
            end
          end
          check("row_size", 32'(bus.o_transize), 32'(e.sz));
          check("row_idx", 32'(bus.o_row_idx), 32'(e.idx));
          check("row_first", 32'(bus.o_first), 32'(e.first));
          check("row_last", 32'(bus.o_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.i_dt_vld   = 1'b0;
    bus.i_transize = 2'd0;
    bus.i_data     = '0;
    bus.i_rdy      = 1'b1;
    bus.i_clr_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_vld", 32'(bus.o_vld), 32'(0));
    check("rst_ovf", 32'(bus.o_ovf), 32'(0));
    check("rst_size_err", 32'(bus.o_size_err), 32'(0));
    check("rst_idx", 32'(bus.o_row_idx), 32'(0));
    check("rst_first_last", 32'({bus.o_first, bus.o_last}), 32'(0));
    check("rst_size", 32'(bus.o_transize), 32'(0));
    check("rst_data_zero", 32'(bus.o_data == '0), 32'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4x4 block: one-cycle latency, no same-cycle bypass, lanes 4..31 zeroed
    chk_nobypass = 1'b1;
    send_row(2'd0, 10, 2'd0, 0, 1'b1);
    chk_nobypass = 1'b0;
    check("latency_vld", 32'(bus.o_vld), 32'(1));
    check("latency_idx", 32'(bus.o_row_idx), 32'(0));
    for (int i = 1; i < 4; i++) send_row(2'd0, 10 + i, 2'd0, i, 1'b1);
    wait_drain(20);

    // 32x32 block, then a 4x4 block must restart at idx0
    for (int i = 0; i < 32; i++) send_row(2'd3, 100 + i, 2'd3, i, 1'b1);
    for (int i = 0; i < 4; i++) send_row(2'd0, 200 + i, 2'd0, i, 1'b1);
    wait_drain(20);

    // 8x8 block with no ready: 4 stored, 5th dropped even while clearing
    bus.i_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_row(2'd1, 300 + i, 2'd1, i, 1'b1);
    check("ovf_before_drop", 32'(bus.o_ovf), 32'(0));
    bus.i_clr_err = 1'b1;
    send_row(2'd1, 304, 2'd1, 4, 1'b0);
    bus.i_clr_err = 1'b0;
    check("ovf_set_wins", 32'(bus.o_ovf), 32'(1));
    bus.i_rdy = 1'b1;
    wait_drain(20);
    for (int i = 5; i < 8; i++) send_row(2'd1, 300 + i, 2'd1, i, 1'b1);
    wait_drain(20);
    check("ovf_sticky", 32'(bus.o_ovf), 32'(1));
    clr_pulse();
    check("ovf_cleared", 32'(bus.o_ovf), 32'(0));

    // Full FIFO with push and pop every cycle: nothing lost, occupancy stays 4
    bus.i_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_row(2'd2, 400 + i, 2'd2, i, 1'b1);
    bus.i_rdy = 1'b1;
    for (int i = 4; i < 14; i++) begin
      send_row(2'd2, 400 + i, 2'd2, i, 1'b1);
      check("full_occupancy", 32'(dut.u_fifo.cnt_q), 32'(4));
    end
    for (int i = 14; i < 16; i++) send_row(2'd2, 400 + i, 2'd2, i, 1'b1);
    wait_drain(20);
    check("no_ovf_push_pop", 32'(bus.o_ovf), 32'(0));

    // 16x16 block with a size glitch on row 5: framing keeps size 2
    for (int i = 0; i < 16; i++) begin
      send_row((i == 5) ? 2'd0 : 2'd2, 500 + i, 2'd2, i, 1'b1);
      if (i == 4 || i == 5 || i == 15)
        check("size_err_flag", 32'(bus.o_size_err), 32'(i >= 5));
    end
    wait_drain(20);
    clr_pulse();
    check("size_err_cleared", 32'(bus.o_size_err), 32'(0));

    // Reset mid-block with both flags set and rows stored
    bus.i_rdy = 1'b0;
    send_row(2'd1, 600, 2'd1, 0, 1'b0);
    send_row(2'd0, 601, 2'd1, 1, 1'b0);
    for (int i = 2; i < 5; i++) send_row(2'd1, 600 + i, 2'd1, i, 1'b0);
    check("pre_rst_flags", 32'({bus.o_ovf, bus.o_size_err, bus.o_vld}), 32'(3'b111));
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(bus.o_vld), 32'(0));
    check("mid_rst_flags", 32'({bus.o_ovf, bus.o_size_err}), 32'(0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.i_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_row(2'd0, 700 + i, 2'd0, i, 1'b1);
    wait_drain(20);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
